// File: rtl/bus_sequencer_if.sv
// rtl/bus_sequencer_if.sv - handshake/bus bundle between the fetch/transfer sequencer and its environment
// The sequencer takes the master modport; the environment (skin memory, register file, host) takes slave.
interface bus_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_start;
    logic                  i_halt_req;
    logic [DATA_WIDTH-1:0] i_instruction;
    logic                  i_mem_ack;
`ifdef SEQ_SINGLE_STEP_EN
    logic                  i_step;
`endif
    logic                  o_mem_req;
    logic [15:0]           o_unit_ien;
    logic [15:0]           o_unit_oen;
    logic                  o_busy;
    logic                  o_halted;
    logic                  o_err;

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        input  i_step,
`endif
        input  i_start, i_halt_req, i_instruction, i_mem_ack,
        output o_mem_req, o_unit_ien, o_unit_oen, o_busy, o_halted, o_err
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        output i_step,
`endif
        output i_start, i_halt_req, i_instruction, i_mem_ack,
        input  o_mem_req, o_unit_ien, o_unit_oen, o_busy, o_halted, o_err
    );
endinterface

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - fetch/decode/exec sequencer driving one-hot bus source/destination enables
// Optional single-step mode under SEQ_SINGLE_STEP_EN (adds i_step and a STEP_WAIT state).
module bus_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic            clk,
    input  logic            rst,
    bus_sequencer_if.master bus
);
    localparam logic [7:0]  CNT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [15:0] EN_IR     = 16'h0002;
    localparam logic [15:0] EN_MEM_RD = 16'h1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_ERROR
`ifdef SEQ_SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    // Where a completed instruction (EXEC or NOP) goes when no halt is pending.
`ifdef SEQ_SINGLE_STEP_EN
    localparam state_t S_DONE = S_STEP_WAIT;
`else
    localparam state_t S_DONE = S_FETCH;
`endif

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] src, dst, src_nxt, dst_nxt;
    logic       err_q, err_nxt;
    logic [7:0] instr;
    logic       is_nop, is_halt, is_legal;

    assign instr    = bus.i_instruction[7:0];
    assign is_nop   = (instr == 8'h00);
    assign is_halt  = (instr == 8'hFF);
    assign is_legal = (instr[7:4] >= 4'd1) && (instr[7:4] <= 4'd7) &&
                      (instr[3:0] >= 4'd1) && (instr[3:0] <= 4'd11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
            src   <= 4'd0;
            dst   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            src   <= src_nxt;
            dst   <= dst_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        src_nxt        = src;
        dst_nxt        = dst;
        err_nxt        = err_q;
        bus.o_mem_req  = 1'b0;
        bus.o_unit_ien = 16'h0000;
        bus.o_unit_oen = 16'h0000;
        case (state)
            S_IDLE: begin
                if (bus.i_start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                bus.o_mem_req = 1'b1;
                // Ack is Mealy: memory drives the bus into IR in the same cycle it acks.
                if (bus.i_mem_ack) begin
                    bus.o_unit_oen = EN_MEM_RD;
                    bus.o_unit_ien = EN_IR;
                    cnt_nxt        = 8'd0;
                    state_nxt      = S_DECODE;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = S_ERROR;
                end else if (bus.i_halt_req) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_HALT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_DECODE: begin
                src_nxt = instr[3:0];
                dst_nxt = instr[7:4];
                if (is_halt) begin
                    state_nxt = S_HALT;
                end else if (is_nop) begin
                    state_nxt = bus.i_halt_req ? S_HALT : S_DONE;
                end else if (!is_legal) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_ERROR;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.o_unit_oen = 16'h0001 << src;
                bus.o_unit_ien = 16'h0001 << dst;
                state_nxt      = bus.i_halt_req ? S_HALT : S_DONE;
            end
            S_HALT: begin
                if (bus.i_start) state_nxt = S_FETCH;
            end
            S_ERROR: begin
                if (bus.i_start) begin
                    err_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (bus.i_halt_req)  state_nxt = S_HALT;
                else if (bus.i_step) state_nxt = S_FETCH;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef SEQ_SINGLE_STEP_EN
    assign bus.o_busy = (state == S_FETCH) || (state == S_DECODE) ||
                        (state == S_EXEC)  || (state == S_STEP_WAIT);
`else
    assign bus.o_busy = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
`endif
    assign bus.o_halted = (state == S_HALT);
    assign bus.o_err    = err_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed self-checking bench for bus_sequencer with a transaction-level model
module tb_bus_sequencer;
    localparam int TIMEOUT = 15;
    localparam int W_IDLE = 0, W_FETCH = 1, W_HALT = 2, W_ERROR = 3;

    typedef struct {
        logic        req;
        logic [15:0] ien;
        logic [15:0] oen;
        logic        busy;
        logic        halted;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t expq[$];

    int   m_where = W_IDLE;
    int   m_cnt   = 0;
    logic m_err   = 1'b0;

    bus_sequencer_if #(.DATA_WIDTH(8)) bif ();

    bus_sequencer #(.DATA_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("cyc_mem_req", 16'(bif.o_mem_req), 16'(e.req));
            chk("cyc_ien",     bif.o_unit_ien,     e.ien);
            chk("cyc_oen",     bif.o_unit_oen,     e.oen);
            chk("cyc_busy",    16'(bif.o_busy),    16'(e.busy));
            chk("cyc_halted",  16'(bif.o_halted),  16'(e.halted));
            chk("cyc_err",     16'(bif.o_err),     16'(e.err));
        end
    end

    task automatic drive(input logic st, input logic hr, input logic ack,
                         input logic [7:0] ins, input exp_t e);
        @(posedge clk);
        #1;
        bif.i_start       = st;
        bif.i_halt_req    = hr;
        bif.i_mem_ack     = ack;
        bif.i_instruction = ins;
        expq.push_back(e);
    endtask

    function automatic exp_t quiet();
        exp_t e;
        e = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, m_err};
        return e;
    endfunction

    // One cycle with no memory ack; expectation follows the coarse model position.
    task automatic tick(input logic st, input logic hr);
        exp_t e;
        e = quiet();
        case (m_where)
            W_IDLE:  if (st) begin m_where = W_FETCH; m_cnt = 0; end
            W_HALT:  begin e.halted = 1'b1; if (st) begin m_where = W_FETCH; m_cnt = 0; end end
            W_ERROR: if (st) begin m_where = W_IDLE; m_err = 1'b0; end
            default: begin
                e.req = 1'b1; e.busy = 1'b1;
                if (m_cnt == TIMEOUT - 1) begin m_where = W_ERROR; m_err = 1'b1; m_cnt = 0; end
                else if (hr) begin m_where = W_HALT; m_cnt = 0; end
                else m_cnt++;
            end
        endcase
        drive(st, hr, 1'b0, bif.i_instruction, e);
    endtask

    // Full instruction starting from a FETCH cycle that is acked at once.
    task automatic run_instr(input logic [7:0] word, input logic hr);
        exp_t e;
        int   dst, src;
        dst = int'(word) / 16;
        src = int'(word) % 16;
        e = quiet(); e.req = 1'b1; e.busy = 1'b1; e.oen = 16'(1 << 12); e.ien = 16'(1 << 1);
        drive(1'b0, hr, 1'b1, word, e);
        m_cnt = 0;
        e = quiet(); e.busy = 1'b1;
        drive(1'b0, hr, 1'b0, word, e);
        if (word == 8'hFF) begin
            m_where = W_HALT;
        end else if (word == 8'h00) begin
            m_where = hr ? W_HALT : W_FETCH;
        end else if (!(dst >= 1 && dst <= 7 && src >= 1 && src <= 11)) begin
            m_where = W_ERROR;
            m_err   = 1'b1;
        end else begin
            e = quiet(); e.busy = 1'b1; e.oen = 16'(1 << src); e.ien = 16'(1 << dst);
            drive(1'b0, hr, 1'b0, word, e);
            m_where = hr ? W_HALT : W_FETCH;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},    16'(bif.o_mem_req), 16'h0);
        chk({tag, "_ien"},    bif.o_unit_ien,     16'h0);
        chk({tag, "_oen"},    bif.o_unit_oen,     16'h0);
        chk({tag, "_busy"},   16'(bif.o_busy),    16'h0);
        chk({tag, "_halted"}, 16'(bif.o_halted),  16'h0);
        chk({tag, "_err"},    16'(bif.o_err),     16'h0);
    endtask

    task automatic mid_reset(input string tag);
        @(posedge clk);
        #1;
        bif.i_start = 1'b0; bif.i_halt_req = 1'b0; bif.i_mem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_where = W_IDLE; m_cnt = 0; m_err = 1'b0;
    endtask

    initial begin
        bif.i_start = 1'b0; bif.i_halt_req = 1'b0; bif.i_mem_ack = 1'b0;
        bif.i_instruction = 8'h00;
`ifdef SEQ_SINGLE_STEP_EN
        bif.i_step = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Hand-computed trace for DR0 <- IR
        tick(1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h41, '{1'b1, 16'h0002, 16'h1000, 1'b1, 1'b0, 1'b0});
        drive(1'b0, 1'b0, 1'b0, 8'h41, '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0});
        drive(1'b0, 1'b0, 1'b0, 8'h41, '{1'b0, 16'h0010, 16'h0002, 1'b1, 1'b0, 1'b0});
        m_where = W_FETCH; m_cnt = 0;

        run_instr(8'h41, 1'b0);
        run_instr(8'h44, 1'b0);
        run_instr(8'h00, 1'b0);
        run_instr(8'h7B, 1'b0);
        run_instr(8'h52, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);

        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        #3;
        chk("halt_nofetch_halted", 16'(bif.o_halted), 16'h1);
        chk("halt_nofetch_req",    16'(bif.o_mem_req), 16'h0);
        tick(1'b1, 1'b0);

        run_instr(8'hFF, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        #3;
        chk("restart_req", 16'(bif.o_mem_req), 16'h1);

        run_instr(8'h0C, 1'b0);
        tick(1'b0, 1'b0);
        #3;
        chk("dst0_err", 16'(bif.o_err), 16'h1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        #3;
        chk("err_cleared", 16'(bif.o_err), 16'h0);
        tick(1'b1, 1'b0);
        run_instr(8'h8C, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        run_instr(8'h1C, 1'b0);
        tick(1'b1, 1'b0);

        tick(1'b1, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b0, 1'b0);
        #3;
        chk("timeout_pre_err", 16'(bif.o_err), 16'h0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #3;
        chk("timeout_err", 16'(bif.o_err), 16'h1);

        mid_reset("rst_in_error");
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        mid_reset("rst_in_fetch");
        tick(1'b1, 1'b0);
        run_instr(8'h41, 1'b0);
        tick(1'b0, 1'b0);

        @(posedge clk);
        #1;
        bif.i_start = 1'b0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
